des_decrypt_core: RTL and testbench

//   Iterative DES decryption engine: takes a 64-bit ciphertext and 64-bit key,

---
 rtl/des_decrypt_core_pkg.sv | 134 +++++++++++++
 rtl/des_decrypt_core_if.sv | 16 +
 rtl/des_decrypt_core_round_f.sv | 35 +++
 rtl/des_decrypt_core.sv | 133 +++++++++++++
 tb/tb_des_decrypt_core.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/des_decrypt_core_pkg.sv
// Shared DES constants: permutation tables, S-box contents, decrypt rotate schedule
// and FSM encoding. Bit 63 (or the MSB) of any vector is DES bit 1.
package des_pkg;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

   localparam int IP_T [64] = '{
      58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

   localparam int FP_T [64] = '{
      40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

   localparam int E_T [48] = '{
      32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

   localparam int P_T [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

   localparam int PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

   localparam int PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   // Right-rotate amount applied to C/D before decrypt round j (K16 first).
   localparam int RSHIFT [1:16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   // Each box is flattened as row*16 + column.
   localparam int SBOX [8][64] = '{
      '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
         0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
        15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
      '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
         3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
        13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
      '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
         1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
      '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
        13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
         3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
      '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
        14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
        11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
      '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
        10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
         4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
      '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
        13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
         6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
      '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
         1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
         2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

   function automatic logic [63:0] perm_ip(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
      return y;
   endfunction

   function automatic logic [63:0] perm_fp(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
      return y;
   endfunction

   function automatic logic [47:0] perm_e(input logic [31:0] x);
      logic [47:0] y;
      y = '0;
      for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
      return y;
   endfunction

   function automatic logic [31:0] perm_p(input logic [31:0] x);
      logic [31:0] y;
      y = '0;
      for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
      return y;
   endfunction

   function automatic logic [55:0] perm_pc1(input logic [63:0] x);
      logic [55:0] y;
      y = '0;
      for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
      return y;
   endfunction

   function automatic logic [47:0] perm_pc2(input logic [55:0] x);
      logic [47:0] y;
      y = '0;
      for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
      return y;
   endfunction

   // Out-of-range rounds (core idle or done) rotate by zero.
   function automatic int rshift_at(input int j);
      return (j >= 1 && j <= 16) ? RSHIFT[j] : 0;
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
      case (n)
         1:       return {x[0], x[27:1]};
         2:       return {x[1:0], x[27:2]};
         default: return x;
      endcase
   endfunction

endpackage

// File: rtl/des_decrypt_core_if.sv
// Block-in / plaintext-out handshake bundle for the DES decrypt core.
interface des_decrypt_core_if;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic [63:0] in_key;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        busy;

   modport master (output in_valid, in_data, in_key, out_ready,
                   input  in_ready, out_valid, out_data, busy);
   modport slave  (input  in_valid, in_data, in_key, out_ready,
                   output in_ready, out_valid, out_data, busy);
endinterface

// File: rtl/des_decrypt_core_round_f.sv
// DES f-function: expand, key-mix, eight S-box lookups, P permutation.
// Purely combinational; the core instantiates one per unrolled round.
module des_sbox
   import des_pkg::*;
#(
   parameter int IDX = 0
) (
   input  logic [5:0] b_i,
   output logic [3:0] s_o
);
   // Row is the outer bit pair, column the inner four bits.
   assign s_o = 4'(SBOX[IDX][{b_i[5], b_i[0], b_i[4:1]}]);
endmodule

module des_round_f
   import des_pkg::*;
(
   input  logic [31:0] r_i,
   input  logic [47:0] k_i,
   output logic [31:0] f_o
);
   logic [47:0] x;
   logic [31:0] s;

   assign x = perm_e(r_i) ^ k_i;

   for (genvar g = 0; g < 8; g++) begin : g_sbox
      des_sbox #(.IDX(g)) u_sbox (
         .b_i (x[47-6*g -: 6]),
         .s_o (s[31-4*g -: 4])
      );
   end

   assign f_o = perm_p(s);
endmodule

// File: rtl/des_decrypt_core.sv
// Iterative DES decryption: ROUNDS_PER_CYCLE Feistel rounds per clock, subkeys
// K16..K1 produced on the fly by right-rotating C/D from the PC1 value.
module des_decrypt_core
   import des_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   des_decrypt_core_if.slave bus
);
   localparam int RPC = ROUNDS_PER_CYCLE;

   state_e      state_q, state_d;
   logic [31:0] l_q, r_q, l_d, r_d;
   logic [27:0] c_q, d_q, c_d, d_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] out_q, out_d;
   logic        ov_q, ov_d;

   logic [31:0] l_fin, r_fin;
   logic [27:0] c_fin, d_fin;
   logic        last_step;

   // Round chain: each stage rotates C/D for its round, then runs one Feistel step.
   for (genvar k = 0; k < RPC; k++) begin : g_rnd
      logic [31:0] l_in, r_in, l_out, r_out, f;
      logic [27:0] c_in, d_in, c_out, d_out;
      logic [47:0] key;

      if (k == 0) begin : g_first
         assign l_in = l_q;
         assign r_in = r_q;
         assign c_in = c_q;
         assign d_in = d_q;
      end else begin : g_chain
         assign l_in = g_rnd[k-1].l_out;
         assign r_in = g_rnd[k-1].r_out;
         assign c_in = g_rnd[k-1].c_out;
         assign d_in = g_rnd[k-1].d_out;
      end

      assign c_out = rotr28(c_in, rshift_at(int'(cnt_q) + k + 1));
      assign d_out = rotr28(d_in, rshift_at(int'(cnt_q) + k + 1));
      assign key   = perm_pc2({c_out, d_out});

      des_round_f u_f (
         .r_i (r_in),
         .k_i (key),
         .f_o (f)
      );

      assign l_out = r_in;
      assign r_out = l_in ^ f;

      if (k == RPC - 1) begin : g_last
         assign l_fin = l_out;
         assign r_fin = r_out;
         assign c_fin = c_out;
         assign d_fin = d_out;
      end
   end

   assign last_step = (cnt_q == 5'(16 - RPC));

   always_comb begin
      state_d = state_q;
      l_d     = l_q;
      r_d     = r_q;
      c_d     = c_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      ov_d    = ov_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               state_d    = RUN;
               {l_d, r_d} = perm_ip(bus.in_data);
               {c_d, d_d} = perm_pc1(bus.in_key);
               cnt_d      = '0;
            end
         end
         RUN: begin
            l_d   = l_fin;
            r_d   = r_fin;
            c_d   = c_fin;
            d_d   = d_fin;
            cnt_d = cnt_q + 5'(RPC);
            if (last_step) begin
               state_d = DONE;
               out_d   = perm_fp({r_fin, l_fin});
               ov_d    = 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
               ov_d    = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         l_q     <= '0;
         r_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         l_q     <= l_d;
         r_q     <= r_d;
         c_q     <= c_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         ov_q    <= ov_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_valid = ov_q;
   assign bus.out_data  = out_q;

endmodule

// File: tb/tb_des_decrypt_core.sv
// Scoreboard bench for des_decrypt_core: one instance unrolled x1, one x4,
// directed FIPS vectors, stall/ignore, back-to-back and mid-block reset cases.
module tb_des_decrypt_core;

   localparam logic [63:0] K2  = 64'h133457799BBCDFF1;
   localparam logic [63:0] CT2 = 64'h85E813540F0AB405;
   localparam logic [63:0] PT2 = 64'h0123456789ABCDEF;
   localparam logic [63:0] K3  = 64'h0E329232EA6D0D73;
   localparam logic [63:0] CT3 = 64'h0000000000000000;
   localparam logic [63:0] PT3 = 64'h8787878787878787;
   localparam logic [63:0] K4  = 64'h123556789ABDDEF0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]       iv, ordy, ir, ov, bz;
   logic [1:0][63:0] idat, ikey, od;

   des_decrypt_core_if if1 ();
   des_decrypt_core_if if4 ();

   assign if1.in_valid  = iv[0];
   assign if1.in_data   = idat[0];
   assign if1.in_key    = ikey[0];
   assign if1.out_ready = ordy[0];
   assign if4.in_valid  = iv[1];
   assign if4.in_data   = idat[1];
   assign if4.in_key    = ikey[1];
   assign if4.out_ready = ordy[1];
   assign ir = {if4.in_ready, if1.in_ready};
   assign ov = {if4.out_valid, if1.out_valid};
   assign bz = {if4.busy, if1.busy};
   assign od = {if4.out_data, if1.out_data};

   des_decrypt_core #(.ROUNDS_PER_CYCLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
   des_decrypt_core #(.ROUNDS_PER_CYCLE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int acc_edge [2] = '{0, 0};
   int hs_edge  [2] = '{0, 0};
   int lat_exp  [2] = '{16, 4};
   logic prev_ov [2] = '{1'b0, 1'b0};
   logic [63:0] exp_q0 [$];
   logic [63:0] exp_q1 [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int qsize(input int d);
      return (d == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   // Monitor: latency on each rising out_valid, data on each output handshake.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            prev_ov[d] = 1'b0;
         end else begin
            if (iv[d] && ir[d]) acc_edge[d] = cyc + 1;
            if (ov[d] && !prev_ov[d]) chk("latency", 64'(cyc - acc_edge[d]), 64'(lat_exp[d]));
            if (ov[d] && ordy[d]) begin
               hs_edge[d] = cyc + 1;
               if (qsize(d) == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_output dut=%0d got %h expected none", d, od[d]);
               end else if (d == 0) begin
                  chk("out_data", od[d], exp_q0.pop_front());
               end else begin
                  chk("out_data", od[d], exp_q1.pop_front());
               end
            end
            prev_ov[d] = ov[d];
         end
      end
   end

   task automatic issue(input int d, input logic [63:0] ct, input logic [63:0] key, input logic [63:0] pt);
      @(posedge clk); #1;
      iv[d] = 1'b1;
      idat[d] = ct;
      ikey[d] = key;
      if (d == 0) exp_q0.push_back(pt); else exp_q1.push_back(pt);
   endtask

   // Returns #1 after the accept edge.
   task automatic wait_accept(input int d);
      int n = 0;
      @(negedge clk);
      while (!(iv[d] && ir[d]) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout dut=%0d got no accept expected accept", d);
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_drain(input int d);
      int n = 0;
      @(negedge clk);
      while ((qsize(d) != 0 || !ir[d]) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout dut=%0d pending=%0d expected 0", d, qsize(d));
      end
   endtask

   // One block with out_ready high; inputs scrambled after accept, RUN flags checked.
   task automatic run_block(input int d, input logic [63:0] ct, input logic [63:0] key, input logic [63:0] pt);
      ordy[d] = 1'b1;
      issue(d, ct, key, pt);
      wait_accept(d);
      iv[d] = 1'b0;
      idat[d] = {$urandom, $urandom};
      ikey[d] = {$urandom, $urandom};
      for (int k = 0; k < lat_exp[d]; k++) begin
         @(negedge clk);
         chk("run_in_ready", 64'(ir[d]), 64'd0);
         chk("run_busy", 64'(bz[d]), 64'd1);
      end
      wait_drain(d);
   endtask

   initial begin
      int n;
      iv = '0;
      ordy = '0;
      idat = '0;
      ikey = '0;

      // Reset state
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_out_valid", 64'(ov[d]), 64'd0);
         chk("rst_out_data", od[d], 64'd0);
         chk("rst_busy", 64'(bz[d]), 64'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 64'(ir[0]), 64'd1);
      chk("rst_in_ready4", 64'(ir[1]), 64'd1);

      // Basic decrypt
      run_block(0, CT2, K2, PT2);

      // Stalled output, in_valid pulses ignored in DONE
      ordy[0] = 1'b0;
      issue(0, CT3, K3, PT3);
      wait_accept(0);
      iv[0] = 1'b0;
      n = 0;
      while (!ov[0] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         failures++;
         $display("FAIL done_timeout got no out_valid expected out_valid");
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("hold_data", od[0], PT3);
         chk("hold_valid", 64'(ov[0]), 64'd1);
         chk("done_in_ready", 64'(ir[0]), 64'd0);
         @(posedge clk); #1;
         iv[0] = (k % 2 == 0);
         idat[0] = {$urandom, $urandom};
      end
      iv[0] = 1'b0;
      @(posedge clk); #1;
      ordy[0] = 1'b1;
      wait_drain(0);
      chk("after_done_busy", 64'(bz[0]), 64'd0);

      // Parity bits ignored
      run_block(0, CT2, K4, PT2);

      // Back-to-back with in_valid and out_ready held high
      ordy[0] = 1'b1;
      issue(0, CT2, K2, PT2);
      wait_accept(0);
      idat[0] = CT3;
      ikey[0] = K3;
      exp_q0.push_back(PT3);
      wait_accept(0);
      iv[0] = 1'b0;
      chk("b2b_accept_gap", 64'(acc_edge[0]), 64'(hs_edge[0] + 1));
      wait_drain(0);

      // Reset mid-block: no output from the aborted block
      issue(0, CT2, K2, PT2);
      wait_accept(0);
      iv[0] = 1'b0;
      repeat (8) @(posedge clk);
      #2 rst_n = 1'b0;
      exp_q0.delete();
      @(negedge clk);
      chk("abort_out_valid", 64'(ov[0]), 64'd0);
      chk("abort_out_data", od[0], 64'd0);
      chk("abort_busy", 64'(bz[0]), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_in_ready", 64'(ir[0]), 64'd1);
      repeat (20) @(negedge clk);
      run_block(0, CT2, K2, PT2);

      // Four rounds per cycle
      run_block(1, CT2, K2, PT2);
      run_block(1, CT3, K3, PT3);

      repeat (5) @(negedge clk);
      chk("q0_empty", 64'(exp_q0.size()), 64'd0);
      chk("q1_empty", 64'(exp_q1.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
